mem_write_packetizer: RTL and testbench
=======================================

# mem_write_packetizer

- Upstream stage of the memory wrapper: turns a raw AXI-Stream word stream into addressed write packets on its master port, which feeds the wrapper's s01 slave port.
- Buffers up to BURST_LEN words and emits each packet as one header word followed by the buffered payload.
- A packet closes on a full burst or on an input tlast.
- Write addresses are generated internally and wrap within the memory.

## Interface
- DATA_WIDTH, 32, word width; only 32 is supported.
- ADDR_WIDTH, 12, memory word-address width; must be 24 or less.
- MEM_SIZE, 4096, memory depth in words; must equal 2**ADDR_WIDTH.
- BURST_LEN, 16, maximum payload words per packet; power of two, 2..128.
- s00_axis_aclk  in  1  single clock for both ports.
- s00_axis_aresetn  in  1  reset; **synchronous, active-low**.
- s00_axis_tdata  in  DATA_WIDTH  payload word.
- s00_axis_tstrb  in  DATA_WIDTH/8  byte strobes, carried through with the word.
- s00_axis_tvalid  in  1  input word valid.
- s00_axis_tlast  in  1  last word of the input frame.
- s00_axis_tready  out  1  input accept.
- m00_axis_tready  in  1  downstream accept.
- m00_axis_tdata  out  DATA_WIDTH  header, payload or parity word.
- m00_axis_tstrb  out  DATA_WIDTH/8  strobes.
- m00_axis_tvalid  out  1  output valid.
- m00_axis_tlast  out  1  last word of the packet.

## Operation
- **FIFO**
  - Depth BURST_LEN; each entry holds {tdata, tstrb, tlast}.
  - A word is accepted when s00_axis_tvalid and s00_axis_tready are both high.
  - s00_axis_tready = not full AND not closed.
  - `closed` sets when a word with tlast is accepted. It clears when that word is popped to the output.
  - Because input stalls while closed, at most one tlast word is ever buffered.
- **Address counter** (addr_q, ADDR_WIDTH bits, reset 0)
  - After a packet's last payload word handshakes: addr_q <= (addr_q + len) mod MEM_SIZE.
  - If that packet ended on an input tlast, addr_q <= 0 instead.
- **State machine**
  - IDLE: launch when count == BURST_LEN or closed. On launch, latch len = count (1..BURST_LEN), then go to HDR.
  - HDR: drive the header word with tstrb all ones and tlast 0.
    - Header bits [31:24] = len - 1.
    - Header bits [23:ADDR_WIDTH] = 0.
    - Header bits [ADDR_WIDTH-1:0] = addr_q.
    - On handshake, go to DATA.
  - DATA: pop the FIFO on each handshake, with tdata and tstrb taken from the entry. tlast is 1 on the len-th word. After the len-th handshake, go to IDLE (or PAR when enabled).
- While in HDR or DATA, input is still accepted if not full and not closed; those words belong to later packets.
- The input tlast bit is not forwarded as-is: output tlast marks the packet end only.

## Timing
- **Reset values**: all outputs 0 (s00_axis_tready 0 during reset, 1 on the first cycle after), FIFO empty, closed 0, addr_q 0, state IDLE.
- **Reset mid-packet**: the packet is dropped, the FIFO is flushed, and no partial tlast is produced.
- **Outputs are registered.** m00_axis_tvalid for the header rises 2 cycles after the handshake of the word that satisfies the launch condition.
- **Throughput**: payload words stream one per cycle while m00_axis_tready is high, with no bubble between header and payload or between payload words.
- **AXI hold rule**: while tvalid is high and tready is low, tdata, tstrb and tlast are held stable and tvalid does not drop.
- **Back-to-back packets**: at least 1 idle cycle (the IDLE evaluation) between the tlast of one packet and the next header.
- **Simultaneous push and pop in DATA**: count is unchanged. A push into a slot freed in the same cycle is allowed only if not full at the start of that cycle.
- **Input tlast with an empty FIFO**: not possible (a tlast word is itself buffered), so the minimum len is 1.

## Configuration
- **MEM_PKT_PARITY_EN defined**
  - After the last payload word, the state machine enters PAR and emits one trailer word.
  - The trailer is the XOR of the header and all payload tdata, with tstrb all ones.
  - tlast moves from the last payload word to the trailer.
  - addr_q updates on the trailer handshake.
- **Undefined**: no PAR state; the packet is header plus len payload words.

## Test plan
- **Full burst**: 16 words 0x100..0x10F, no tlast, tready held 1 → header 0x0F000000, then 0x100..0x10F, tlast on 0x10F; next header 0x0F000010.
- **Short frame**: 3 words with tlast on the 3rd → header 0x02000000, 3 payload words, tlast on the 3rd; tready low until that word pops; addr_q returns to 0.
- **Backpressure**: m00_axis_tready toggled 1,0,0,1 during DATA → every stalled word held stable; no loss or duplication; FIFO fill causes s00_axis_tready to fall at 16 words.
- **Wrap**: 256 full bursts with ADDR_WIDTH 12 → the 257th header address is 0x000.
- **Reset mid-packet**: assert reset after the header plus 5 payload words → outputs 0 the next cycle; after release a new 2-word frame yields header 0x01000000.
- **Parity (MEM_PKT_PARITY_EN)**: frame 0x1, 0x2 with tlast → words 0x01000000, 0x1, 0x2, trailer 0x01000003 with tlast.

Source files
------------

// File: rtl/mem_write_packetizer.sv
// Packs an AXI-Stream word stream into addressed write packets (header + up to BURST_LEN words).
// Optional feature macro: MEM_PKT_PARITY_EN appends an XOR trailer word to each packet.
module mem_write_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_SIZE   = 4096,
    parameter int BURST_LEN  = 16
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    input  logic                    m00_axis_tready,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast
);

    // state  | meaning
    // IDLE   | wait for a full burst or a buffered tlast, then load the header
    // HDR    | header word on the output, waiting for its handshake
    // DATA   | payload words streaming out of the FIFO
    // PAR    | XOR trailer word on the output (MEM_PKT_PARITY_EN only)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_PAR  = 2'd3
    } state_t;

    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + SW + 1;
    localparam logic [CW-1:0] FULL = CW'(BURST_LEN);

`ifdef MEM_PKT_PARITY_EN
    localparam bit PL_TLAST_EN = 1'b0;
`else
    localparam bit PL_TLAST_EN = 1'b1;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  end_tlast_q, end_tlast_d;
    logic                  tvalid_d, tlast_d, tready_d;
    logic [DATA_WIDTH-1:0] tdata_d;
    logic [SW-1:0]         tstrb_d;
`ifdef MEM_PKT_PARITY_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

    logic [EW-1:0]         fifo_mem [BURST_LEN];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  closed_q, closed_d;
    logic                  push, pop, hs;
    logic [EW-1:0]         rd_entry;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [SW-1:0]         rd_strb;
    logic                  rd_last;
    logic [23:0]           hdr_field;
    logic [DATA_WIDTH-1:0] hdr_word;

    assign push     = s00_axis_tvalid && s00_axis_tready;
    assign hs       = m00_axis_tvalid && m00_axis_tready;
    assign rd_entry = fifo_mem[rd_ptr_q];
    assign rd_data  = rd_entry[EW-1 -: DATA_WIDTH];
    assign rd_strb  = rd_entry[SW:1];
    assign rd_last  = rd_entry[0];

    always_comb begin
        hdr_field = '0;
        hdr_field[ADDR_WIDTH-1:0] = addr_q;
        hdr_word = {8'(count_q - CW'(1)), hdr_field};
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};
        end
    end

    // A buffered tlast word blocks input until it has been moved to the output register.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        closed_d = closed_q;
        if (push && s00_axis_tlast) begin
            closed_d = 1'b1;
        end else if (pop && rd_last) begin
            closed_d = 1'b0;
        end
        tready_d = (count_d != FULL) && !closed_d;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        end_tlast_d = end_tlast_q;
        tvalid_d    = m00_axis_tvalid;
        tdata_d     = m00_axis_tdata;
        tstrb_d     = m00_axis_tstrb;
        tlast_d     = m00_axis_tlast;
        pop         = 1'b0;
`ifdef MEM_PKT_PARITY_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q == FULL || closed_q) begin
                    len_d       = count_q;
                    end_tlast_d = closed_q;
                    tvalid_d    = 1'b1;
                    tdata_d     = hdr_word;
                    tstrb_d     = '1;
                    tlast_d     = 1'b0;
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                if (hs) begin
                    pop     = 1'b1;
                    tdata_d = rd_data;
                    tstrb_d = rd_strb;
                    tlast_d = PL_TLAST_EN && (len_q == CW'(1));
                    idx_d   = CW'(1);
                    state_d = S_DATA;
`ifdef MEM_PKT_PARITY_EN
                    acc_d   = m00_axis_tdata;
`endif
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (idx_q == len_q) begin
`ifdef MEM_PKT_PARITY_EN
                        tdata_d  = acc_q ^ m00_axis_tdata;
                        tstrb_d  = '1;
                        tlast_d  = 1'b1;
                        state_d  = S_PAR;
`else
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tstrb_d  = '0;
                        tlast_d  = 1'b0;
                        addr_d   = end_tlast_q ? '0 : addr_q + ADDR_WIDTH'(len_q);
                        state_d  = S_IDLE;
`endif
                    end else begin
                        pop     = 1'b1;
                        tdata_d = rd_data;
                        tstrb_d = rd_strb;
                        tlast_d = PL_TLAST_EN && (idx_q + CW'(1) == len_q);
                        idx_d   = idx_q + CW'(1);
`ifdef MEM_PKT_PARITY_EN
                        acc_d   = acc_q ^ m00_axis_tdata;
`endif
                    end
                end
            end
`ifdef MEM_PKT_PARITY_EN
            S_PAR: begin
                if (hs) begin
                    tvalid_d = 1'b0;
                    tdata_d  = '0;
                    tstrb_d  = '0;
                    tlast_d  = 1'b0;
                    addr_d   = end_tlast_q ? '0 : addr_q + ADDR_WIDTH'(len_q);
                    state_d  = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            idx_q           <= '0;
            addr_q          <= '0;
            end_tlast_q     <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            closed_q        <= 1'b0;
            s00_axis_tready <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tlast  <= 1'b0;
`ifdef MEM_PKT_PARITY_EN
            acc_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            addr_q          <= addr_d;
            end_tlast_q     <= end_tlast_d;
            wr_ptr_q        <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q        <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_q         <= count_d;
            closed_q        <= closed_d;
            s00_axis_tready <= tready_d;
            m00_axis_tvalid <= tvalid_d;
            m00_axis_tdata  <= tdata_d;
            m00_axis_tstrb  <= tstrb_d;
            m00_axis_tlast  <= tlast_d;
`ifdef MEM_PKT_PARITY_EN
            acc_q           <= acc_d;
`endif
        end
    end

    if (DATA_WIDTH != 32) begin : g_chk_dw
        $error("mem_write_packetizer: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH > 24) begin : g_chk_aw
        $error("mem_write_packetizer: ADDR_WIDTH must be 24 or less");
    end
    if (MEM_SIZE != (1 << ADDR_WIDTH)) begin : g_chk_ms
        $error("mem_write_packetizer: MEM_SIZE must equal 2**ADDR_WIDTH");
    end
    if (BURST_LEN < 2 || BURST_LEN > 128 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_chk_bl
        $error("mem_write_packetizer: BURST_LEN must be a power of two in 2..128");
    end

endmodule

// File: tb/tb_mem_write_packetizer.sv
// Directed self-checking bench for mem_write_packetizer (BURST_LEN 16, ADDR_WIDTH 12).
`timescale 1ns/1ps
module tb_mem_write_packetizer;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef MEM_PKT_PARITY_EN
    localparam bit LAST_PL = 1'b0;
`else
    localparam bit LAST_PL = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tstrb = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tvalid;
    logic          m_tlast;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_par = '0;

    always #5 clk = ~clk;

    mem_write_packetizer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12),
        .MEM_SIZE  (4096),
        .BURST_LEN (16)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        bit took;
        took = 1'b0;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !took; i++) begin
            took = s_tready;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("push_accept", 32'(took), 32'd1);
    endtask

    // Waits (bounded) for an output handshake, checks the word, then lets the handshake happen.
    task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic [SW-1:0] s,
                              input logic l, input int max_wait);
        int w;
        w = 0;
        while (!(m_tvalid && m_tready) && w < max_wait) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, 32'(m_tvalid), 32'd1);
        check({tag, "_data"}, m_tdata, d);
        check({tag, "_strb"}, 32'(m_tstrb), 32'(s));
        check({tag, "_last"}, 32'(m_tlast), 32'(l));
        tick();
    endtask

    task automatic expect_hdr(input string tag, input logic [DW-1:0] d, input int max_wait);
        exp_par = d;
        expect_out(tag, d, '1, 1'b0, max_wait);
    endtask

    task automatic expect_pl(input string tag, input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic l);
        exp_par = exp_par ^ d;
        expect_out(tag, d, s, l & LAST_PL, 0);
    endtask

    task automatic end_pkt(input string tag);
`ifdef MEM_PKT_PARITY_EN
        expect_out({tag, "_par"}, exp_par, '1, 1'b1, 0);
`else
        check({tag, "_no_trailer"}, 32'(m_tvalid), 32'd0);
`endif
    endtask

    task automatic full_burst(input string tag, input logic [DW-1:0] base, input logic [DW-1:0] hdr);
        for (int j = 0; j < 16; j++) push(base + DW'(j), '1, 1'b0);
        expect_hdr({tag, "_hdr"}, hdr, 4);
        for (int j = 0; j < 16; j++) expect_pl({tag, "_pl"}, base + DW'(j), '1, j == 15);
        end_pkt(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        tick();
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tstrb", 32'(m_tstrb), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_s_tready", 32'(s_tready), 32'd1);

        // Short frame: three words, tlast on the third
        m_tready = 1'b1;
        push(32'h300, 4'h1, 1'b0);
        push(32'h301, 4'h3, 1'b0);
        push(32'h302, 4'hC, 1'b1);
        check("sf_closed_s_tready", 32'(s_tready), 32'd0);
        expect_hdr("sf_hdr", 32'h0200_0000, 4);
        check("sf_hold_s_tready", 32'(s_tready), 32'd0);
        expect_pl("sf_pl0", 32'h300, 4'h1, 1'b0);
        expect_pl("sf_pl1", 32'h301, 4'h3, 1'b0);
        expect_pl("sf_pl2", 32'h302, 4'hC, 1'b1);
        end_pkt("sf");
        check("sf_reopen_s_tready", 32'(s_tready), 32'd1);

        // Full burst after a tlast frame: address back at 0, header two cycles after the 16th word
        for (int j = 0; j < 16; j++) push(32'h100 + DW'(j), '1, 1'b0);
        check("fb_full_s_tready", 32'(s_tready), 32'd0);
        check("fb_hdr_lat_idle", 32'(m_tvalid), 32'd0);
        tick();
        check("fb_hdr_lat_valid", 32'(m_tvalid), 32'd1);
        expect_hdr("fb_hdr", 32'h0F00_0000, 0);
        for (int j = 0; j < 16; j++) expect_pl("fb_pl", 32'h100 + DW'(j), '1, j == 15);
        end_pkt("fb");
        tick();
        check("fb_idle_after", 32'(m_tvalid), 32'd0);

        // Backpressure: FIFO fills, header held, ready pattern 1,0,0,1 in DATA
        m_tready = 1'b0;
        for (int j = 0; j < 16; j++) push(32'h200 + DW'(j), '1, 1'b0);
        check("bp_full_s_tready", 32'(s_tready), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_hdr_hold_valid", 32'(m_tvalid), 32'd1);
            check("bp_hdr_hold_data", m_tdata, 32'h0F00_0010);
            check("bp_hdr_hold_s_tready", 32'(s_tready), 32'd0);
            tick();
        end
        m_tready = 1'b1;
        expect_hdr("bp_hdr", 32'h0F00_0010, 0);
        check("bp_refill_s_tready", 32'(s_tready), 32'd1);
        expect_pl("bp_pl0", 32'h200, '1, 1'b0);
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("bp_stall_valid", 32'(m_tvalid), 32'd1);
            check("bp_stall_data", m_tdata, 32'h201);
            check("bp_stall_last", 32'(m_tlast), 32'd0);
            tick();
        end
        m_tready = 1'b1;
        for (int j = 1; j < 16; j++) expect_pl("bp_pl", 32'h200 + DW'(j), '1, j == 15);
        end_pkt("bp");

        // Address wrap: bursts 3..256 walk the address to the top of memory
        for (int k = 0; k < 254; k++) begin
            full_burst("wrap", 32'h1000 + DW'(k * 16), 32'h0F00_0000 | DW'((32 + 16 * k) % 4096));
        end

        // 257th burst header wraps to 0, then reset after header + 5 payload words
        for (int j = 0; j < 16; j++) push(32'h400 + DW'(j), '1, 1'b0);
        expect_hdr("wrap_hdr257", 32'h0F00_0000, 4);
        for (int j = 0; j < 5; j++) expect_pl("mr_pl", 32'h400 + DW'(j), '1, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mr_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mr_m_tlast", 32'(m_tlast), 32'd0);
        check("mr_m_tdata", m_tdata, 32'd0);
        check("mr_s_tready", 32'(s_tready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_quiet_valid", 32'(m_tvalid), 32'd0);
            check("mr_quiet_last", 32'(m_tlast), 32'd0);
        end
        check("mr_s_tready_back", 32'(s_tready), 32'd1);
        push(32'h500, 4'hF, 1'b0);
        push(32'h501, 4'hF, 1'b1);
        expect_hdr("mr_hdr", 32'h0100_0000, 4);
        expect_pl("mr_new0", 32'h500, 4'hF, 1'b0);
        expect_pl("mr_new1", 32'h501, 4'hF, 1'b1);
        end_pkt("mr");

        // Frame 0x1, 0x2 with tlast
        push(32'h1, 4'hF, 1'b0);
        push(32'h2, 4'hF, 1'b1);
        expect_hdr("p2_hdr", 32'h0100_0000, 4);
        expect_pl("p2_pl0", 32'h1, 4'hF, 1'b0);
        expect_pl("p2_pl1", 32'h2, 4'hF, 1'b1);
`ifdef MEM_PKT_PARITY_EN
        expect_out("p2_trailer", 32'h0100_0003, 4'hF, 1'b1, 0);
`else
        check("p2_no_trailer", 32'(m_tvalid), 32'd0);
`endif
        tick();
        check("p2_idle_after", 32'(m_tvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
